// File: rtl/ac_thermostat.sv
// Heat/cool thermostat with hysteresis, min on/off dwell, mode select and sensor-timeout fault.
// One-cycle registered response; no flow control (sample stream, outputs are levels).
module ac_thermostat #(
  parameter int TEMP_W   = 5,
  parameter int HEAT_ON  = 18,
  parameter int HEAT_OFF = 20,
  parameter int COOL_ON  = 22,
  parameter int COOL_OFF = 20,
  parameter int MIN_ON   = 4,
  parameter int MIN_OFF  = 3,
  parameter int TIMEOUT  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        mode,
  input  logic [TEMP_W-1:0] temperature,
  input  logic              temp_valid,
  output logic              heating,
  output logic              cooling,
  output logic [1:0]        state,
  output logic              dwell_active,
  output logic              fault
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    HEAT = 2'b01,
    COOL = 2'b10
  } state_t;

  localparam logic [1:0] MODE_OFF  = 2'b00;
  localparam logic [1:0] MODE_AUTO = 2'b01;
  localparam logic [1:0] MODE_HEAT = 2'b10;
  localparam logic [1:0] MODE_COOL = 2'b11;

  localparam int DW = (MIN_ON > MIN_OFF) ? MIN_ON : MIN_OFF;
  localparam int TW = (DW > 1) ? $clog2(DW) : 1;
  localparam int CW = $clog2(TIMEOUT + 1);

  localparam logic [TW-1:0]     ON_LOAD    = TW'(MIN_ON - 1);
  localparam logic [TW-1:0]     OFF_LOAD   = TW'(MIN_OFF - 1);
  localparam logic [CW-1:0]     INV_MAX    = CW'(TIMEOUT);
  localparam logic [TEMP_W-1:0] T_HEAT_ON  = TEMP_W'(HEAT_ON);
  localparam logic [TEMP_W-1:0] T_HEAT_OFF = TEMP_W'(HEAT_OFF);
  localparam logic [TEMP_W-1:0] T_COOL_ON  = TEMP_W'(COOL_ON);
  localparam logic [TEMP_W-1:0] T_COOL_OFF = TEMP_W'(COOL_OFF);

  state_t        state_q;
  logic [TW-1:0] timer;
  logic [CW-1:0] inv_cnt;

  logic [CW-1:0] inv_next;
  logic [TW-1:0] timer_dec;
  logic          inv_sat;
  logic          can_move;
  logic          to_heat;
  logic          to_cool;
  logic          heat_exit;
  logic          cool_exit;
  logic          force_idle;

  assign inv_next  = temp_valid ? '0 : ((inv_cnt == INV_MAX) ? inv_cnt : inv_cnt + CW'(1));
  assign inv_sat   = !temp_valid && (inv_next == INV_MAX);
  assign timer_dec = (timer == '0) ? '0 : timer - TW'(1);
  assign can_move  = temp_valid && !fault && (timer == '0);

  assign to_heat   = (temperature <= T_HEAT_ON) && (mode == MODE_AUTO || mode == MODE_HEAT);
  assign to_cool   = (temperature >= T_COOL_ON) && (mode == MODE_AUTO || mode == MODE_COOL);
  assign heat_exit = (temperature >= T_HEAT_OFF) || (mode == MODE_COOL);
  assign cool_exit = (temperature <= T_COOL_OFF) || (mode == MODE_HEAT);

  // OFF and sensor timeout both drop an active output immediately, bypassing the dwell.
  assign force_idle = (state_q != IDLE) && (inv_sat || mode == MODE_OFF);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      timer   <= '0;
      inv_cnt <= '0;
      fault   <= 1'b0;
    end else begin
      inv_cnt <= inv_next;
      if (temp_valid)
        fault <= 1'b0;
      else if (inv_sat)
        fault <= 1'b1;

      if (force_idle) begin
        state_q <= IDLE;
        timer   <= OFF_LOAD;
      end else if (can_move && state_q == IDLE && to_heat) begin
        state_q <= HEAT;
        timer   <= ON_LOAD;
      end else if (can_move && state_q == IDLE && to_cool) begin
        state_q <= COOL;
        timer   <= ON_LOAD;
      end else if (can_move && ((state_q == HEAT && heat_exit) || (state_q == COOL && cool_exit))) begin
        state_q <= IDLE;
        timer   <= OFF_LOAD;
      end else begin
        timer <= timer_dec;
      end
    end
  end

  assign state        = state_q;
  assign heating      = (state_q == HEAT);
  assign cooling      = (state_q == COOL);
  assign dwell_active = (timer != '0);

endmodule

// File: tb/tb_ac_thermostat.sv
// Directed + randomized bench for ac_thermostat, checked against a cycle-age reference model.
module tb_ac_thermostat;

  localparam int TEMP_W   = 5;
  localparam int HEAT_ON  = 18;
  localparam int HEAT_OFF = 20;
  localparam int COOL_ON  = 22;
  localparam int COOL_OFF = 20;
  localparam int MIN_ON   = 4;
  localparam int MIN_OFF  = 3;
  localparam int TIMEOUT  = 8;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [1:0]        mode;
  logic [TEMP_W-1:0] temperature;
  logic              temp_valid;
  logic              heating;
  logic              cooling;
  logic [1:0]        state;
  logic              dwell_active;
  logic              fault;

  int checks = 0;
  int errors = 0;

  // Reference model: state 0/1/2, how many cycles it has been held, whether IDLE
  // carries an off-dwell, the current run of invalid samples, and the fault flag.
  int m_state;
  int m_age;
  bit m_guard;
  int m_streak;
  bit m_fault;

  always #5 clk = ~clk;

  ac_thermostat #(
    .TEMP_W(TEMP_W), .HEAT_ON(HEAT_ON), .HEAT_OFF(HEAT_OFF), .COOL_ON(COOL_ON),
    .COOL_OFF(COOL_OFF), .MIN_ON(MIN_ON), .MIN_OFF(MIN_OFF), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .mode(mode), .temperature(temperature),
    .temp_valid(temp_valid), .heating(heating), .cooling(cooling), .state(state),
    .dwell_active(dwell_active), .fault(fault)
  );

  function automatic void model_reset();
    m_state  = 0;
    m_age    = 0;
    m_guard  = 1'b0;
    m_streak = 0;
    m_fault  = 1'b0;
  endfunction

  function automatic void model_step();
    int t, md, nxt;
    bit v, held_enough;
    t  = int'(temperature);
    md = int'(mode);
    v  = temp_valid;
    m_streak = v ? 0 : ((m_streak < TIMEOUT) ? m_streak + 1 : TIMEOUT);
    if (m_state != 0) held_enough = (m_age >= MIN_ON);
    else              held_enough = !m_guard || (m_age >= MIN_OFF);
    nxt = m_state;
    if (m_state != 0 && ((!v && m_streak == TIMEOUT) || md == 0)) begin
      nxt = 0;
    end else if (v && !m_fault && held_enough) begin
      case (m_state)
        0: begin
          if (t <= HEAT_ON && (md == 1 || md == 2))      nxt = 1;
          else if (t >= COOL_ON && (md == 1 || md == 3)) nxt = 2;
        end
        1: if (t >= HEAT_OFF || md == 3) nxt = 0;
        default: if (t <= COOL_OFF || md == 2) nxt = 0;
      endcase
    end
    if (nxt != m_state) begin
      m_guard = (nxt == 0);
      m_age   = 1;
      m_state = nxt;
    end else if (m_age < 100) begin
      m_age++;
    end
    if (v) m_fault = 1'b0;
    else if (m_streak == TIMEOUT) m_fault = 1'b1;
  endfunction

  task automatic chk(input string tag, input string fld, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s.%s observed=%0h expected=%0h", tag, fld, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    bit exp_dwell;
    exp_dwell = (m_state != 0) ? (m_age < MIN_ON) : (m_guard && m_age < MIN_OFF);
    chk(tag, "state",   {6'd0, state},        8'(m_state));
    chk(tag, "heating", {7'd0, heating},      {7'd0, m_state == 1});
    chk(tag, "cooling", {7'd0, cooling},      {7'd0, m_state == 2});
    chk(tag, "dwell",   {7'd0, dwell_active}, {7'd0, exp_dwell});
    chk(tag, "fault",   {7'd0, fault},        {7'd0, m_fault});
    chk(tag, "exclusive", {7'd0, heating & cooling}, 8'd0);
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    if (rst_n) model_step();
    else       model_reset();
    #1;
    check_all(tag);
  endtask

  task automatic set(input int md, input int t, input bit v);
    mode        = 2'(md);
    temperature = TEMP_W'(t);
    temp_valid  = v;
  endtask

  initial begin
    int cool_cycles, idle_before_heat, tw, burst;
    bit seen_heat;

    rst_n = 1'b0;
    set(1, 16, 1'b1);
    model_reset();
    #2;
    check_all("reset");
    #10;
    rst_n = 1'b1;

    // Entry into HEAT on the first edge, with three cycles of on-dwell.
    tick("entry");
    chk("entry", "heat_now", {7'd0, heating}, 8'd1);
    tick("entry");
    tick("entry");
    chk("entry", "dwell_last", {7'd0, dwell_active}, 8'd1);
    tick("entry");
    chk("entry", "dwell_done", {7'd0, dwell_active}, 8'd0);

    // Hysteresis band and inclusive thresholds.
    set(1, 19, 1'b1); tick("hyst19");
    chk("hyst19", "stay_heat", {6'd0, state}, 8'd1);
    set(1, 20, 1'b1); tick("hyst20");
    chk("hyst20", "to_idle", {6'd0, state}, 8'd0);
    set(1, 21, 1'b1); tick("hyst21");
    set(1, 22, 1'b1); tick("hyst22");
    chk("hyst22", "still_idle", {6'd0, state}, 8'd0);
    tick("hyst22");
    chk("hyst22", "to_cool", {6'd0, state}, 8'd2);

    // Dwell guard: demand heat right after entering COOL.
    set(1, 16, 1'b1);
    cool_cycles = 1;
    idle_before_heat = 0;
    seen_heat = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick("dwell");
      if (!seen_heat) begin
        if (cooling) cool_cycles++;
        else if (heating) seen_heat = 1'b1;
        else idle_before_heat++;
      end
    end
    chk("dwell", "cool_cycles", 8'(cool_cycles), 8'd4);
    chk("dwell", "idle_cycles", 8'(idle_before_heat), 8'd3);

    // HEAT_ONLY never cools; OFF drops HEAT mid-dwell.
    set(2, 25, 1'b1);
    repeat (6) tick("heat_only");
    chk("heat_only", "idle", {6'd0, state}, 8'd0);
    set(1, 16, 1'b1);
    tick("off_prep");
    tick("off_prep");
    chk("off_prep", "timer2", {6'd0, state}, 8'd1);
    set(0, 16, 1'b1);
    tick("off");
    chk("off", "forced_idle", {6'd0, state}, 8'd0);
    repeat (4) tick("off_hold");

    // Sensor timeout while cooling, then recovery.
    set(1, 24, 1'b1);
    repeat (8) tick("fault_prep");
    chk("fault_prep", "in_cool", {6'd0, state}, 8'd2);
    set(1, 24, 1'b0);
    for (int i = 1; i <= TIMEOUT; i++) begin
      tick("fault_run");
      if (i < TIMEOUT) chk("fault_run", "held", {6'd0, state}, 8'd2);
    end
    chk("fault_run", "fault_set", {7'd0, fault}, 8'd1);
    chk("fault_run", "cool_off", {7'd0, cooling}, 8'd0);
    set(1, 24, 1'b1);
    tick("fault_clr");
    chk("fault_clr", "cleared", {7'd0, fault}, 8'd0);
    tick("fault_clr");
    tick("fault_clr");
    chk("fault_clr", "recool", {6'd0, state}, 8'd2);

    // Asynchronous reset between edges.
    set(1, 16, 1'b1);
    repeat (10) tick("areset_prep");
    chk("areset_prep", "heating", {7'd0, heating}, 8'd1);
    #3;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all("areset");
    #2;
    rst_n = 1'b1;
    tick("areset_rel");

    // Randomized: random-walk temperature, sporadic mode changes and invalid bursts.
    tw = 20;
    burst = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 15) == 0) begin
        if ($urandom_range(0, 1) == 1) mode = 2'd1;
        else mode = 2'($urandom_range(0, 3));
      end
      tw = tw + int'($urandom_range(0, 4)) - 2;
      if ($urandom_range(0, 63) == 0) tw = int'($urandom_range(10, 30));
      if (tw < 0) tw = 0;
      if (tw > 31) tw = 31;
      temperature = TEMP_W'(tw);
      if (burst > 0) begin
        temp_valid = 1'b0;
        burst--;
      end else if ($urandom_range(0, 39) == 0) begin
        temp_valid = 1'b0;
        burst = int'($urandom_range(0, 11));
      end else begin
        temp_valid = 1'b1;
      end
      tick("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
